// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with byte enables, write-first bypass and a clear sequencer.
// Define RAM_OUTREG_EN to add a second output register stage (read latency 2).
module ram_dp_clr #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2**ADDR_W,
    parameter int unsigned BE_W   = DATA_W/8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              clr_req,
    output logic              busy
);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              waddr_ok;
    logic              raddr_ok;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] rdata_s1;
    logic              rvalid_s1;

    // Address qualification, byte mask and write-first read data
    always_comb begin
        waddr_ok = ({1'b0, waddr} < DEPTH_X);
        raddr_ok = ({1'b0, raddr} < DEPTH_X);
        wr_en    = (state == IDLE) && we && waddr_ok;
        rd_en    = (state == IDLE) && re;
        wmask    = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            wmask[8*i +: 8] = {8{wbe[i]}};
        end
        rd_word = raddr_ok ? mem[raddr] : '0;
        rd_next = rd_word;
        if (wr_en && (waddr == raddr)) begin
            rd_next = (wdata & wmask) | (rd_word & ~wmask);
        end
    end

    // Clear sequencer and first read stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            rdata_s1  <= '0;
            rvalid_s1 <= 1'b0;
        end else begin
            rvalid_s1 <= rd_en;
            if (rd_en) begin
                rdata_s1 <= rd_next;
            end
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array writes: zeroing while clearing, byte-masked user writes when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < int'(BE_W); i++) begin
                    if (wbe[i]) begin
                        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef RAM_OUTREG_EN
    // Second output stage; shifts during CLEAR so an in-flight read still lands
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rvalid_s1;
            if (rvalid_s1) begin
                rdata <= rdata_s1;
            end
        end
    end
`else
    assign rdata  = rdata_s1;
    assign rvalid = rvalid_s1;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: vector table, corner sequences, random traffic vs a model.
module tb_ram_dp_clr;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          clr_req = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wbe = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: array contents, remaining busy cycles, read result pipeline
    logic [DW-1:0] mm [DEPTH];
    int            clr_left = 0;
    logic          v1 = 1'b0, ov = 1'b0;
    logic [DW-1:0] d1 = '0, od = '0;

    logic [DW-1:0] got [DEPTH];
    int            n_got, span;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [3:0]    wbe;
        logic          re;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [11];

    ram_dp_clr dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_edge();
        logic          rv;
        logic [DW-1:0] rd;
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) mm[a] = '0;
            clr_left = DEPTH;
            v1 = 1'b0; d1 = '0; ov = 1'b0; od = '0;
            return;
        end
        rv = 1'b0;
        rd = '0;
        if (clr_left == 0 && re) begin
            rv = 1'b1;
            rd = (int'(raddr) < DEPTH) ? mm[raddr] : '0;
            if (we && waddr == raddr && int'(waddr) < DEPTH) rd = merge(rd, wdata, wbe);
        end
        if (clr_left > 0) begin
            clr_left--;
        end else begin
            if (we && int'(waddr) < DEPTH) mm[waddr] = merge(mm[waddr], wdata, wbe);
            if (clr_req) begin
                for (int a = 0; a < DEPTH; a++) mm[a] = '0;
                clr_left = DEPTH;
            end
        end
        if (LAT == 2) begin
            ov = v1;
            if (v1) od = d1;
        end
        v1 = rv;
        if (rv) d1 = rd;
        if (LAT == 1) begin
            ov = v1;
            od = d1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(busy), 32'(clr_left > 0));
        chk("rvalid", 32'(rvalid), 32'(ov));
        chk("rdata", rdata, od);
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; re = 1'b0; clr_req = 1'b0; wbe = '0;
    endtask

    // Counts busy samples, optionally re-requesting a clear and writing while busy
    task automatic busy_run(input int req_at, input bit noise, output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            clr_req = (n == req_at);
            if (noise) begin
                we = 1'b1; waddr = AW'($urandom); wdata = $urandom; wbe = 4'hF;
            end
            step();
        end
        clr_req = 1'b0;
    endtask

    task automatic read_stream();
        int k, first, last;
        k = 0; first = -1; last = -1;
        for (int i = 0; i < DEPTH + LAT + 1; i++) begin
            we = 1'b0;
            re = (i < DEPTH);
            raddr = AW'(i);
            step();
            if (rvalid === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                if (k < DEPTH) got[k] = rdata;
                k++;
            end
        end
        idle();
        n_got = k;
        span = last - first;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, nz;
        tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'h00, 32'h0};
        tbl[1]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 8'h00, 32'h0};
        tbl[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 32'hDE22BE44};
        tbl[3]  = '{1'b1, 8'h20, 32'h12345678, 4'hF, 1'b0, 8'h00, 32'h0};
        tbl[4]  = '{1'b1, 8'h20, 32'hCAFEF00D, 4'hC, 1'b1, 8'h20, 32'hCAFE5678};
        tbl[5]  = '{1'b1, 8'h30, 32'hAABBCCDD, 4'h0, 1'b1, 8'h30, 32'h0};
        tbl[6]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h30, 32'h0};
        tbl[7]  = '{1'b1, 8'h11, 32'h0000FFFF, 4'h3, 1'b1, 8'h10, 32'hDE22BE44};
        tbl[8]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h11, 32'h0000FFFF};
        tbl[9]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h05, 32'h0};
        tbl[10] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h20, 32'hCAFE5678};

        // Reset clear with a read held pending throughout
        rst = 1'b1; re = 1'b1; raddr = 8'd5;
        step();
        rst = 1'b0;
        busy_run(0, 1'b0, n);
        chk("reset_clear_len", 32'(n), 32'(DEPTH));
        repeat (LAT) step();
        chk("first_read_valid", 32'(rvalid), 32'd1);
        chk("first_read_data", rdata, 32'h0);
        idle();
        step();

        // Vector table: byte enables, bypass, no-op write, independent ports
        for (int i = 0; i < 11; i++) begin
            we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata; wbe = tbl[i].wbe;
            re = tbl[i].re; raddr = tbl[i].raddr;
            step();
            if (tbl[i].re) begin
                idle();
                repeat (LAT - 1) step();
                chk($sformatf("vec%0d_valid", i), 32'(rvalid), 32'd1);
                chk($sformatf("vec%0d_data", i), rdata, tbl[i].exp);
            end
        end
        idle();
        step();

        // Streaming reads of mem[i] = i*3
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = DW'(i * 3); wbe = 4'hF;
            step();
        end
        idle();
        read_stream();
        chk("stream_count", 32'(n_got), 32'(DEPTH));
        chk("stream_span", 32'(span), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) chk($sformatf("stream_data%0d", i), got[i], 32'(i * 3));

        // Runtime clear with a second request and writes while busy
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = $urandom | 32'h1; wbe = 4'hF;
            step();
        end
        idle();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_run(100, 1'b1, n);
        idle();
        chk("runtime_clear_len", 32'(n), 32'(DEPTH));
        read_stream();
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (got[i] !== 32'h0) nz++;
        chk("clear_readback_count", 32'(n_got), 32'(DEPTH));
        chk("clear_readback_nonzero", 32'(nz), 32'h0);

        // Reset in the middle of a clear restarts it
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (127) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_run(0, 1'b0, n);
        chk("reset_midclear_len", 32'(n), 32'(DEPTH));
        idle();

        // Random traffic on a small address window to stress bypass
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 1499) == 0);
            clr_req = ($urandom_range(0, 799) == 0);
            we      = 1'($urandom_range(0, 1));
            re      = 1'($urandom_range(0, 1));
            waddr   = AW'($urandom_range(0, 15));
            raddr   = AW'($urandom_range(0, 15));
            wdata   = $urandom;
            wbe     = 4'($urandom);
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised simple dual-port synchronous RAM: one write port, one read port, single clock. It is the successor to the single-port `ram`. It adds per-byte write enables, registered reads with a valid flag, write-first read-during-write bypass, and a built-in clear sequencer. The sequencer zeroes the whole array after reset or on request. It serves as the general data/register-file store for the CPU datapath.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 8, address width in bits
DEPTH, 2**ADDR_W, number of words; must be <= 2**ADDR_W
BE_W, DATA_W/8, byte-enable width (derived; do not override)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
we  in  1  write request
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
wbe  in  BE_W  byte enables; bit i selects wdata[8i+7:8i]
re  in  1  read request
raddr  in  ADDR_W  read address
rdata  out  DATA_W  read data, registered
rvalid  out  1  rdata valid; one-cycle pulse per accepted read
clr_req  in  1  start a clear of the whole array
busy  out  1  clear sequencer active; user traffic blocked

Behaviour:
- Reset values: rdata=0, rvalid=0, busy=1. FSM enters CLEAR with clr_cnt=0.
- rst asserted mid-clear or mid-traffic: the clear restarts from address 0. Any pending read is dropped, so rvalid=0 on the next cycle.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes 0 to mem[clr_cnt] each cycle; clr_cnt increments.
  - CLEAR exit: when clr_cnt==DEPTH-1 is written, the next state is IDLE. busy deasserts on the first IDLE cycle.
  - Clear duration: exactly DEPTH cycles of busy after rst falls.
  - IDLE: clr_req=1 moves to CLEAR with clr_cnt=0; busy=1 from the next cycle.
  - clr_req while busy=1 is ignored; it does not extend or restart the clear.
- While busy=1:
  - we is ignored; the array is not modified by the user.
  - re is ignored; rvalid stays 0 and rdata holds its previous value.
- Write (IDLE, we=1): mem[waddr] byte i <= wdata byte i for each wbe[i]=1. Other bytes are unchanged.
  - we=1 with wbe=0: no-op.
  - waddr >= DEPTH: write dropped.
- Read (IDLE, re=1): rdata <= mem[raddr] at the next edge, and rvalid=1 for that cycle. Latency is 1 cycle.
  - re=0: rvalid=0 and rdata holds.
  - raddr >= DEPTH: rdata=0 and rvalid=1.
- Read-during-write to the same address in the same cycle is write-first. Enabled bytes come from wdata; disabled bytes come from old mem contents.
- Simultaneous read and write to different addresses are independent.
- clr_req and we in the same IDLE cycle: the write is performed, then CLEAR starts next cycle and overwrites it.
- clr_req and re in the same IDLE cycle: the read completes normally with pre-clear data.
- Back-to-back reads: one result per cycle; rvalid stays high continuously.

Optional Feature:
RAM_OUTREG_EN
- Defined: an extra output register stage is added.
  - Read latency becomes 2 cycles; rvalid is delayed identically.
  - Write-first bypass still applies, taken from the read-issue cycle.
  - rst clears both stages.
  - A read accepted in the cycle before clr_req still completes, with rvalid asserted during CLEAR.
- Undefined: latency is 1 cycle as above; no extra flops.

Test Plan:
- Reset clear: pulse rst 1 cycle, hold re=1 raddr=5 -> busy high exactly 256 cycles with rvalid=0 throughout. First IDLE read of addr 5 returns 0x00000000 with rvalid=1 one cycle later.
- Byte-enable write:
  - write 0xDEADBEEF to addr 0x10 with wbe=0xF, then write 0x11223344 with wbe=0x5.
  - read addr 0x10 -> 0xDE22BE44.
- Bypass: same cycle we=1 waddr=0x20 wdata=0xCAFEF00D wbe=0xC (old value 0x12345678) and re=1 raddr=0x20 -> rdata=0xCAFE5678 next cycle.
- Runtime clear:
  - fill addr 0..255 with random data, assert clr_req 1 cycle, and assert clr_req again at cycle 100 of the clear.
  - expected: busy high exactly 256 cycles; the second request is ignored; full readback returns all 0.
  - we pulses during busy leave the array at 0.
- Reset mid-clear: assert rst at cycle 128 of a clear -> clear restarts; busy stays high for 256 further cycles after rst falls.
- Streaming reads: re=1 for 256 cycles, raddr=0..255 after writing mem[i]=i*3 -> rvalid continuous and rdata sequence 0,3,6,…,765. With RAM_OUTREG_EN, the same sequence is shifted by one further cycle.
